// File: rtl/kbd_mouse_decode.sv
// Keyboard/mouse event decoder: two mouse X/Y/wheel accumulators with a packet-phase FSM
// per mouse, a first-word-fall-through keyboard FIFO with sticky overflow, and an OSD key register.
module kbd_mouse_decode #(
  parameter int KBD_DEPTH = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       kms_strobe,
  input  logic [1:0] kms_type,
  input  logic [7:0] kms_data,
  input  logic       mouse_idx,
  input  logic       kbd_rd,
  output logic [7:0] kbd_data,
  output logic       kbd_valid,
  output logic       kbd_ovf,
  input  logic       kbd_ovf_clr,
  output logic [7:0] osd_key,
  output logic       osd_strobe,
  output logic [7:0] mouse0_x,
  output logic [7:0] mouse0_y,
  output logic [7:0] mouse0_w,
  output logic [7:0] mouse1_x,
  output logic [7:0] mouse1_y,
  output logic [7:0] mouse1_w,
  output logic [3:0] dbg_phase
);

  localparam int AW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_Y     = 2'd1,
    PH_WHEEL = 2'd2
  } phase_t;

  phase_t     r_phase [2];
  phase_t     w_phase_nxt [2];
  logic [1:0] w_sel;
  logic [1:0] w_add_x;
  logic [1:0] w_add_y;
  logic [1:0] w_add_w;
  logic [7:0] r_mx [2];
  logic [7:0] r_my [2];
  logic [7:0] r_mw [2];

  // Phase FSM: state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_phase[0] <= PH_IDLE;
      r_phase[1] <= PH_IDLE;
    end else begin
      r_phase[0] <= w_phase_nxt[0];
      r_phase[1] <= w_phase_nxt[1];
    end
  end

  // Phase FSM: next state. X always restarts a packet; type 1 walks Y -> WHEEL -> IDLE.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      w_phase_nxt[m] = r_phase[m];
      if (w_sel[m]) begin
        if (kms_type == 2'd0) begin
          w_phase_nxt[m] = PH_Y;
        end else if (kms_type == 2'd1) begin
          case (r_phase[m])
            PH_Y:     w_phase_nxt[m] = PH_WHEEL;
            PH_WHEEL: w_phase_nxt[m] = PH_IDLE;
            default:  w_phase_nxt[m] = PH_IDLE;
          endcase
        end
      end
    end
  end

  // Phase FSM: outputs (counter update enables)
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      w_sel[m]   = kms_strobe && (mouse_idx == 1'(m));
      w_add_x[m] = w_sel[m] && (kms_type == 2'd0);
      w_add_y[m] = w_sel[m] && (kms_type == 2'd1) && (r_phase[m] == PH_Y);
      w_add_w[m] = w_sel[m] && (kms_type == 2'd1) && (r_phase[m] == PH_WHEEL);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int m = 0; m < 2; m++) begin
        r_mx[m] <= 8'h00;
        r_my[m] <= 8'h00;
        r_mw[m] <= 8'h00;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (w_add_x[m]) r_mx[m] <= r_mx[m] + kms_data;
        if (w_add_y[m]) r_my[m] <= r_my[m] + kms_data;
        if (w_add_w[m]) r_mw[m] <= r_mw[m] + kms_data;
      end
    end
  end

  assign mouse0_x  = r_mx[0];
  assign mouse0_y  = r_my[0];
  assign mouse0_w  = r_mw[0];
  assign mouse1_x  = r_mx[1];
  assign mouse1_y  = r_my[1];
  assign mouse1_w  = r_mw[1];
  assign dbg_phase = {r_phase[1], r_phase[0]};

  // Keyboard FIFO
  logic [7:0]    r_mem [KBD_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_push_req;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;

  assign w_push_req = kms_strobe && (kms_type == 2'd2);
  assign w_full     = (r_count == CW'(KBD_DEPTH));
  assign w_pop      = kbd_rd && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= kms_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (kbd_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign kbd_data  = r_mem[r_rd_ptr];
  assign kbd_valid = (r_count != '0);
  assign kbd_ovf   = r_ovf;

  // OSD key
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      osd_key    <= 8'h00;
      osd_strobe <= 1'b0;
    end else begin
      osd_strobe <= kms_strobe && (kms_type == 2'd3);
      if (kms_strobe && (kms_type == 2'd3)) osd_key <= kms_data;
    end
  end

endmodule

// File: tb/tb_kbd_mouse_decode.sv
// Directed bench for kbd_mouse_decode: mouse packets, FIFO overflow/full push-pop, OSD, reset.
module tb_kbd_mouse_decode;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       kms_strobe = 1'b0;
  logic [1:0] kms_type = 2'd0;
  logic [7:0] kms_data = 8'h00;
  logic       mouse_idx = 1'b0;
  logic       kbd_rd = 1'b0;
  logic       kbd_ovf_clr = 1'b0;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ovf;
  logic [7:0] osd_key;
  logic       osd_strobe;
  logic [7:0] mouse0_x, mouse0_y, mouse0_w;
  logic [7:0] mouse1_x, mouse1_y, mouse1_w;
  logic [3:0] dbg_phase;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  kbd_mouse_decode #(.KBD_DEPTH(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kms_strobe(kms_strobe), .kms_type(kms_type),
    .kms_data(kms_data), .mouse_idx(mouse_idx), .kbd_rd(kbd_rd), .kbd_data(kbd_data),
    .kbd_valid(kbd_valid), .kbd_ovf(kbd_ovf), .kbd_ovf_clr(kbd_ovf_clr), .osd_key(osd_key),
    .osd_strobe(osd_strobe), .mouse0_x(mouse0_x), .mouse0_y(mouse0_y), .mouse0_w(mouse0_w),
    .mouse1_x(mouse1_x), .mouse1_y(mouse1_y), .mouse1_w(mouse1_w), .dbg_phase(dbg_phase)
  );

  // driver tasks: all return 1 time unit after a rising edge
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic strobe(input logic [1:0] t, input logic [7:0] d, input logic idx);
    kms_strobe = 1'b1; kms_type = t; kms_data = d; mouse_idx = idx;
    @(posedge clk_sys); #1;
    kms_strobe = 1'b0;
  endtask

  task automatic pop();
    kbd_rd = 1'b1;
    @(posedge clk_sys); #1;
    kbd_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] got;
    do_reset();
    got = {mouse0_x, mouse0_y, mouse0_w, mouse1_x, mouse1_y, mouse1_w, osd_key, 8'h00};
    n_checks++;
    if (got !== 64'h0) begin
      n_fail++; $display("FAIL reset_counters got=%h exp=%h", got, 64'h0);
    end
    n_checks++;
    if ({kbd_valid, kbd_ovf, osd_strobe, dbg_phase} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=%b", {kbd_valid, kbd_ovf, osd_strobe, dbg_phase}, 7'b0);
    end
  endtask

  task automatic test_mouse_packet();
    strobe(2'd0, 8'h05, 1'b0);
    strobe(2'd1, 8'hFE, 1'b0);
    strobe(2'd1, 8'h01, 1'b0);
    n_checks++;
    if ({mouse0_x, mouse0_y, mouse0_w} !== 24'h05FE01) begin
      n_fail++; $display("FAIL m0_packet got=%h exp=%h", {mouse0_x, mouse0_y, mouse0_w}, 24'h05FE01);
    end
    n_checks++;
    if ({mouse1_x, mouse1_y, mouse1_w} !== 24'h000000) begin
      n_fail++; $display("FAIL m1_untouched got=%h exp=%h", {mouse1_x, mouse1_y, mouse1_w}, 24'h0);
    end
    // mouse 1 X while mouse 0 is idle: mouse 0 type 1 is dropped, mouse 1 Y accepted
    strobe(2'd0, 8'h10, 1'b1);
    strobe(2'd1, 8'h22, 1'b0);
    strobe(2'd1, 8'h33, 1'b1);
    n_checks++;
    if ({mouse0_y, mouse1_x, mouse1_y} !== 24'hFE1033) begin
      n_fail++; $display("FAIL mouse_idx_sel got=%h exp=%h", {mouse0_y, mouse1_x, mouse1_y}, 24'hFE1033);
    end
  endtask

  task automatic test_no_strobe();
    kms_type = 2'd0; kms_data = 8'h77; mouse_idx = 1'b0; kbd_rd = 1'b0;
    idle(2);
    n_checks++;
    if ({mouse0_x, kbd_valid} !== {8'h05, 1'b0}) begin
      n_fail++; $display("FAIL no_strobe got=%h/%b exp=05/0", mouse0_x, kbd_valid);
    end
  endtask

  task automatic test_idle_discard_wrap();
    do_reset();
    strobe(2'd1, 8'h33, 1'b0);
    n_checks++;
    if ({mouse0_y, mouse0_w} !== 16'h0000) begin
      n_fail++; $display("FAIL idle_discard got=%h exp=%h", {mouse0_y, mouse0_w}, 16'h0);
    end
    strobe(2'd0, 8'h7F, 1'b0);
    strobe(2'd0, 8'h02, 1'b0);
    n_checks++;
    if (mouse0_x !== 8'h81) begin
      n_fail++; $display("FAIL x_wrap_7f got=%h exp=81", mouse0_x);
    end
    strobe(2'd0, 8'h7E, 1'b0);
    strobe(2'd0, 8'h01, 1'b0);
    n_checks++;
    if (mouse0_x !== 8'h00) begin
      n_fail++; $display("FAIL x_wrap_ff got=%h exp=00", mouse0_x);
    end
    strobe(2'd1, 8'h80, 1'b0);
    strobe(2'd1, 8'hFF, 1'b0);
    strobe(2'd1, 8'h11, 1'b0);
    n_checks++;
    if ({mouse0_y, mouse0_w, dbg_phase[1:0]} !== {8'h80, 8'hFF, 2'd0}) begin
      n_fail++; $display("FAIL y_w_then_idle got=%h exp=%h", {mouse0_y, mouse0_w, dbg_phase[1:0]}, {8'h80, 8'hFF, 2'd0});
    end
  endtask

  task automatic test_fifo_overflow();
    int bad;
    do_reset();
    for (int i = 0; i < 9; i++) strobe(2'd2, 8'(8'h10 + i), 1'b0);
    n_checks++;
    if ({kbd_ovf, kbd_valid} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_set got=%b exp=11", {kbd_ovf, kbd_valid});
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (kbd_valid !== 1'b1 || kbd_data !== 8'(8'h10 + i)) begin
        n_fail++; bad++;
        $display("FAIL pop_order[%0d] got=%h/%b exp=%h/1", i, kbd_data, kbd_valid, 8'(8'h10 + i));
      end
      pop();
    end
    n_checks++;
    if (kbd_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_after_pops got=%b exp=0", kbd_valid);
    end
    // pop on empty must not move pointers
    pop();
    strobe(2'd2, 8'hA5, 1'b0);
    n_checks++;
    if ({kbd_valid, kbd_data} !== {1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL underflow_ignored got=%b/%h exp=1/a5", kbd_valid, kbd_data);
    end
    pop();
    kbd_ovf_clr = 1'b1; idle(1); kbd_ovf_clr = 1'b0;
    n_checks++;
    if (kbd_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr got=%b exp=0", kbd_ovf);
    end
    for (int i = 0; i < 8; i++) strobe(2'd2, 8'(i), 1'b0);
    kbd_ovf_clr = 1'b1;
    strobe(2'd2, 8'hEE, 1'b0);
    kbd_ovf_clr = 1'b0;
    n_checks++;
    if (kbd_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", kbd_ovf);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q[$];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      strobe(2'd2, 8'(8'h20 + i), 1'b0);
      exp_q.push_back(8'(8'h20 + i));
    end
    kbd_rd = 1'b1;
    strobe(2'd2, 8'h55, 1'b0);
    kbd_rd = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    n_checks++;
    if ({kbd_ovf, kbd_valid, kbd_data} !== {1'b0, 1'b1, 8'h21}) begin
      n_fail++; $display("FAIL full_push_pop got=%b%b/%h exp=01/21", kbd_ovf, kbd_valid, kbd_data);
    end
    while (exp_q.size() > 0) begin
      n_checks++;
      if (kbd_valid !== 1'b1 || kbd_data !== exp_q[0]) begin
        n_fail++; $display("FAIL drain got=%h/%b exp=%h/1", kbd_data, kbd_valid, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pop();
    end
    n_checks++;
    if (kbd_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty got=%b exp=0", kbd_valid);
    end
  endtask

  task automatic test_osd();
    strobe(2'd2, 8'h66, 1'b0);
    strobe(2'd3, 8'h45, 1'b0);
    n_checks++;
    if ({osd_strobe, osd_key} !== {1'b1, 8'h45}) begin
      n_fail++; $display("FAIL osd_load got=%b/%h exp=1/45", osd_strobe, osd_key);
    end
    idle(1);
    n_checks++;
    if ({osd_strobe, osd_key, kbd_valid, kbd_data} !== {1'b0, 8'h45, 1'b1, 8'h66}) begin
      n_fail++; $display("FAIL osd_one_cycle got=%b/%h/%b/%h exp=0/45/1/66", osd_strobe, osd_key, kbd_valid, kbd_data);
    end
    // back-to-back OSD strobes
    kms_strobe = 1'b1; kms_type = 2'd3; kms_data = 8'h01;
    @(posedge clk_sys); #1;
    kms_data = 8'h02;
    n_checks++;
    if ({osd_strobe, osd_key} !== {1'b1, 8'h01}) begin
      n_fail++; $display("FAIL osd_b2b_1 got=%b/%h exp=1/01", osd_strobe, osd_key);
    end
    @(posedge clk_sys); #1;
    kms_strobe = 1'b0;
    n_checks++;
    if ({osd_strobe, osd_key} !== {1'b1, 8'h02}) begin
      n_fail++; $display("FAIL osd_b2b_2 got=%b/%h exp=1/02", osd_strobe, osd_key);
    end
    idle(1);
    n_checks++;
    if (osd_strobe !== 1'b0) begin
      n_fail++; $display("FAIL osd_b2b_end got=%b exp=0", osd_strobe);
    end
  endtask

  task automatic test_reset_mid();
    strobe(2'd0, 8'h09, 1'b1);
    for (int i = 0; i < 3; i++) strobe(2'd2, 8'(8'h30 + i), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mouse1_x, kbd_valid, kbd_ovf, osd_key, osd_strobe, dbg_phase} !== 24'h0) begin
      n_fail++; $display("FAIL async_reset got=%h/%b/%b/%h/%b/%b exp=0",
                         mouse1_x, kbd_valid, kbd_ovf, osd_key, osd_strobe, dbg_phase);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    idle(1);
    strobe(2'd1, 8'h44, 1'b1);
    n_checks++;
    if ({mouse1_x, mouse1_y, mouse1_w} !== 24'h0) begin
      n_fail++; $display("FAIL post_reset_y_discard got=%h exp=0", {mouse1_x, mouse1_y, mouse1_w});
    end
    strobe(2'd0, 8'h03, 1'b1);
    n_checks++;
    if (mouse1_x !== 8'h03) begin
      n_fail++; $display("FAIL post_reset_x got=%h exp=03", mouse1_x);
    end
  endtask

  initial begin
    test_reset();
    test_mouse_packet();
    test_no_strobe();
    test_idle_discard_wrap();
    test_fifo_overflow();
    test_push_pop_full();
    test_osd();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
